// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
// Optional overlap mode is selected by the SEQ_DETECT_OVERLAP_EN macro.
package seq_detect_pkg;

    localparam int unsigned STATE_W = 3;

    // Pattern bits are consumed MSB-first in arrival order.
    localparam logic [3:0] PATTERN = 4'b1011;

    typedef enum logic [STATE_W-1:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_1011.sv
// Serial 1011 detector: registered match pulse, saturating match counter, state debug output.
// Define SEQ_DETECT_OVERLAP_EN to reuse the trailing "10" of a match for the next one.
module seq_detect_1011
    import seq_detect_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state_dbg
);

    state_e state_q;
    state_e state_d;
    logic   match_q;
    logic   match_d;

    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            unique case (state_q)
                S0:    state_d = (din == PATTERN[3]) ? S1    : S0;
                S1:    state_d = (din == PATTERN[2]) ? S10   : S1;
                S10:   state_d = (din == PATTERN[1]) ? S101  : S0;
                S101:  state_d = (din == PATTERN[0]) ? S1011 : S10;
                S1011: begin
                    if (din) begin
                        state_d = S1;
                    end else begin
`ifdef SEQ_DETECT_OVERLAP_EN
                        state_d = S10;
`else
                        state_d = S0;
`endif
                    end
                end
                default: state_d = S0;
            endcase
        end
    end

    // S1011 is only ever entered from S101, so entering it marks exactly one detection.
    assign match_d = din_valid && (state_d == S1011);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_d),
        .clr   (clr),
        .count (match_cnt)
    );

    assign match     = match_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011: vector table plus hand-written multi-cycle sequences.
module tb_seq_detect_1011;

`ifdef SEQ_DETECT_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       clr;
    logic       match;
    logic [7:0] match_cnt;
    logic [2:0] state_dbg;
    logic       match2;
    logic [1:0] match_cnt2;
    logic [2:0] state_dbg2;

    int total;
    int passed;

    seq_detect_1011 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr       (clr),
        .match     (match),
        .match_cnt (match_cnt),
        .state_dbg (state_dbg)
    );

    // Narrow-counter instance sharing the stimulus, for saturation checks.
    seq_detect_1011 #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr       (clr),
        .match     (match2),
        .match_cnt (match_cnt2),
        .state_dbg (state_dbg2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       din;
        logic       valid;
        logic       clr;
        logic       exp_match;
        logic [7:0] exp_cnt;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic v, input logic c);
        din       = d;
        din_valid = v;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, hold two edges, release mid-cycle.
    task automatic do_reset();
        din_valid = 1'b0;
        clr       = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] pat;
        logic [2:0] gap_state [4];
        total  = 0;
        passed = 0;
        pat    = 4'b1011;
        gap_state[0] = 3'd1;
        gap_state[1] = 3'd2;
        gap_state[2] = 3'd3;
        gap_state[3] = 3'd4;

        // din, valid, clr, exp_match, exp_cnt, exp_state
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd2};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 3'd4};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, OVL ? 3'd2 : 3'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, OVL ? 3'd3 : 3'd1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, OVL, OVL ? 8'd2 : 8'd1, OVL ? 3'd4 : 3'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, OVL ? 8'd2 : 8'd1, 3'd2};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, OVL ? 8'd2 : 8'd1, 3'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, OVL ? 8'd2 : 8'd1, 3'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, OVL ? 8'd2 : 8'd1, 3'd3};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, OVL ? 8'd3 : 8'd2, 3'd4};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, OVL ? 8'd3 : 8'd2, 3'd1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd2};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 3'd4};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd4};

        din       = 1'b0;
        din_valid = 1'b0;
        clr       = 1'b0;
        rst       = 1'b0;
        #1;
        check("reset_match", {31'd0, match}, 32'd0);
        check("reset_cnt", {24'd0, match_cnt}, 32'd0);
        check("reset_state", {29'd0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].din, vecs[i].valid, vecs[i].clr);
            check($sformatf("vec%0d_match", i), {31'd0, match}, {31'd0, vecs[i].exp_match});
            check($sformatf("vec%0d_cnt", i), {24'd0, match_cnt}, {24'd0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_state", i), {29'd0, state_dbg}, {29'd0, vecs[i].exp_state});
        end

        // Valid gaps with din toggling between pattern bits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(pat[3-i], 1'b1, 1'b0);
            check($sformatf("gap_bit%0d_state", i), {29'd0, state_dbg}, {29'd0, gap_state[i]});
            check($sformatf("gap_bit%0d_match", i), {31'd0, match}, (i == 3) ? 32'd1 : 32'd0);
            for (int g = 0; g < 3; g++) begin
                step(g[0], 1'b0, 1'b0);
                check($sformatf("gap%0d_%0d_state", i, g), {29'd0, state_dbg},
                      {29'd0, gap_state[i]});
                check($sformatf("gap%0d_%0d_match", i, g), {31'd0, match}, 32'd0);
            end
        end
        check("gap_cnt", {24'd0, match_cnt}, 32'd1);

        // Five back-to-back detections: narrow counter saturates at 3.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            for (int b = 0; b < 4; b++) begin
                step(pat[3-b], 1'b1, 1'b0);
            end
            check($sformatf("sat%0d_match", k), {31'd0, match2}, 32'd1);
            check($sformatf("sat%0d_cnt8", k), {24'd0, match_cnt}, k);
            check($sformatf("sat%0d_cnt2", k), {30'd0, match_cnt2}, (k > 3) ? 32'd3 : k);
        end
        step(1'b0, 1'b0, 1'b0);
        check("sat_hold_cnt2", {30'd0, match_cnt2}, 32'd3);
        check("sat_hold_match", {31'd0, match2}, 32'd0);

        // Partial pattern then asynchronous reset, observed before any clock edge.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_rst_state", {29'd0, state_dbg}, 32'd3);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state", {29'd0, state_dbg}, 32'd0);
        check("async_rst_cnt", {24'd0, match_cnt}, 32'd0);
        check("async_rst_cnt2", {30'd0, match_cnt2}, 32'd0);
        check("async_rst_match", {31'd0, match}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("post_rst_state", {29'd0, state_dbg}, 32'd1);
        check("post_rst_match", {31'd0, match}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("post_rst_match2", {31'd0, match}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_detect_1011.md
SEQ_DETECT_1011 -- requirements
Module: seq_detect_1011

Interface
REQ-001 Parameter: CNT_W, 8, width of the match counter.
REQ-002 Port: clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: din  input  1  serial bit, driven directly by the upstream D flip-flop q output.
REQ-005 Port: din_valid  input  1  din is sampled only on clock edges where din_valid=1.
REQ-006 Port: clr  input  1  synchronous clear of match_cnt.
REQ-007 Port: match  output  1  one-cycle pulse per detected pattern 1011.
REQ-008 Port: match_cnt  output  CNT_W  saturating count of detected patterns.
REQ-009 Port: state_dbg  output  3  current FSM state encoding.

Function
REQ-010 The FSM SHALL have five states, consuming din MSB-first in arrival order: S0=0 (idle), S1=1 (seen "1"), S10=2, S101=3, S1011=4.
REQ-011 Transitions on valid bits SHALL be: S0 -(1)-> S1, S0 -(0)-> S0.
REQ-012 Transitions on valid bits SHALL be: S1 -(1)-> S1, S1 -(0)-> S10.
REQ-013 Transitions on valid bits SHALL be: S10 -(1)-> S101, S10 -(0)-> S0.
REQ-014 Transitions on valid bits SHALL be: S101 -(1)-> S1011, S101 -(0)-> S10.
REQ-015 Transitions out of S1011 SHALL be: on 1 -> S1; on 0 -> S10 with OVERLAP_EN, or S0 without it.
REQ-016 When din_valid=0, state, match_cnt and state_dbg SHALL hold, and match SHALL be 0 on the next cycle.
REQ-017 match SHALL be registered: it is 1 in the cycle after the edge on which a valid bit moves the FSM into S1011, for exactly one cycle. Latency is 1 clock from the sampling of the final '1'.
REQ-018 match_cnt SHALL increment by 1 on every edge that produces a match pulse, and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-019 clr=1 SHALL set match_cnt to 0 on the next edge. It does not affect the FSM or match.
REQ-020 If clr and a detection coincide, match_cnt SHALL become 0 (clr wins) while match still pulses.
REQ-021 state_dbg SHALL equal the registered state value, with no combinational path from din.

Reset
REQ-022 rst=0 SHALL asynchronously force: state=S0, match=0, match_cnt=0, state_dbg=0.
REQ-023 Reset asserted mid-pattern SHALL discard the partial pattern. After release, detection restarts from S0 at the first valid bit.
REQ-024 Reset deassertion SHALL take effect on the next rising clk edge only.

Configuration
REQ-025 Macro SEQ_DETECT_OVERLAP_EN, when defined, SHALL enable overlapping detection: the trailing "10" after a match is reused.
REQ-026 Without SEQ_DETECT_OVERLAP_EN, detection SHALL be non-overlapping: after a match, a 0 returns the FSM to S0, and a 1 goes to S1.

Structure
REQ-027 A shared package seq_detect_pkg SHALL hold the state typedef (3-bit enum S0..S1011) and the constant PATTERN=4'b1011.
REQ-028 The saturating counter SHALL be a separate sub-module sat_counter (parameter W; inputs inc, clr; clr has priority).
REQ-029 The FSM, next-state logic and match register SHALL reside in seq_detect_1011.

Verification
REQ-030 Reset check: rst=0 asserted mid-stream -> all outputs are 0 immediately, without waiting for a clk edge.
REQ-031 Basic detection: valid bits 1,0,1,1 on consecutive cycles -> one match pulse one cycle after the 4th bit, match_cnt=1, state_dbg=4.
REQ-032 Overlap behaviour: bits 1,0,1,1,0,1,1 -> 2 pulses and match_cnt=2 with SEQ_DETECT_OVERLAP_EN; 1 pulse and match_cnt=1 without it.
REQ-033 Valid gaps: bits 1,0,1,1 with din_valid=0 for 3 cycles between each bit, and din toggling during the gaps -> exactly one match and no state change during the gaps.
REQ-034 Counter saturation and clr: with CNT_W=2, 5 detections -> match_cnt=3 and held; clr asserted on the same edge as a detection -> match=1, match_cnt=0.
REQ-035 Reset mid-pattern: bits 1,0,1, then rst=0 for 2 cycles, release, then bit 1 -> no match and state_dbg=1.
